// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: operand fetch with same-cycle
// writeback bypass, immediate generation, load-use hazard detection and bubble insertion.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              ex_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              reg_write;
    logic              is_load;
    logic              illegal;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;

  // Decoded fields of the instruction currently in ID
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm;
  logic              uses_rs1, uses_rs2;
  logic              dec_is_load, dec_illegal, dec_no_rd;
  logic              hazard;

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];

  // Read addresses are raw instruction slices, independent of if_valid.
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise an unlisted opcode leaves it unassigned and a latch is inferred.
  always_comb begin
    imm         = '0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    dec_is_load = 1'b0;
    dec_illegal = 1'b0;
    dec_no_rd   = 1'b0;
    case (opcode)
      OP_IMM, OP_JALR: begin
        imm = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_LOAD: begin
        imm         = {{20{if_instr[31]}}, if_instr[31:20]};
        dec_is_load = 1'b1;
      end
      OP_STORE: begin
        imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        uses_rs2  = 1'b1;
        dec_no_rd = 1'b1;
      end
      OP_BRANCH: begin
        imm       = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                     if_instr[30:25], if_instr[11:8], 1'b0};
        uses_rs2  = 1'b1;
        dec_no_rd = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = {if_instr[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm      = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      OP_REG: begin
        uses_rs2 = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // The register file writes on the same edge EX captures, so a matching
  // writeback must be taken from the write port rather than the stale read.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_AW-1:0] src,
    input logic [XLEN-1:0]   rf_val,
    input logic              we,
    input logic [REG_AW-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    if (src == '0)
      return '0;
    else if (we && (waddr == src))
      return wdata;
    else
      return rf_val;
  endfunction

  // A load in EX cannot forward until MEM completes, so a dependent consumer waits one cycle.
  assign hazard = if_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                  ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));

  assign id_stall = hazard && !flush;

  always_comb begin
    ex_d = ex_q;
    if (flush || hazard) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.is_load   = 1'b0;
      ex_d.illegal   = 1'b0;
    end else begin
      ex_d.valid     = if_valid;
      ex_d.pc        = if_pc;
      ex_d.rs1_val   = sel_operand(rs1, rf_rd1, wb_we, wb_rd, wb_data);
      ex_d.rs2_val   = sel_operand(rs2, rf_rd2, wb_we, wb_rd, wb_data);
      ex_d.imm       = imm;
      ex_d.rs1       = rs1;
      ex_d.rs2       = rs2;
      ex_d.rd        = rd;
      ex_d.opcode    = opcode;
      ex_d.funct3    = if_instr[14:12];
      ex_d.funct7b5  = if_instr[30];
      // Control flags are qualified by if_valid so an empty slot never looks live downstream.
      ex_d.reg_write = if_valid && !dec_no_rd && (rd != '0);
      ex_d.is_load   = if_valid && dec_is_load;
      ex_d.illegal   = if_valid && dec_illegal;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_is_load   = ex_q.is_load;
  assign ex_illegal   = ex_q.illegal;

endmodule
